// File: rtl/fetch_decode_buffer_if.sv
// rtl/fetch_decode_buffer_if.sv - fetch/decode handshake bundle for the IF/ID buffer
// master drives fetch words and decode control, slave is the buffer itself.
interface fetch_decode_buffer_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 16
);
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;
  logic               if_ready;
  logic               id_stall;
  logic               flush;
  logic               id_valid;
  logic [INSTR_W-1:0] id_instr;
  logic [INSTR_W-1:0] id_imm;
  logic [ADDR_W-1:0]  id_pc;
  logic               id_has_imm;

  modport master (
    output if_valid, if_instr, if_pc, id_stall, flush,
    input  if_ready, id_valid, id_instr, id_imm, id_pc, id_has_imm
  );

  modport slave (
    input  if_valid, if_instr, if_pc, id_stall, flush,
    output if_ready, id_valid, id_instr, id_imm, id_pc, id_has_imm
  );
endinterface

// File: rtl/fetch_decode_buffer.sv
// rtl/fetch_decode_buffer.sv - IF/ID stage assembling one- and two-word instructions
// An opcode word with IMM_BIT set is parked until its immediate word arrives.
module fetch_decode_buffer #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 16,
  parameter int IMM_BIT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_decode_buffer_if.slave  bus
);
  typedef enum logic {S_OP, S_IMM} state_t;

  state_t             state, state_nx;
  logic               hold, accept, complete, pend_load;
  logic [INSTR_W-1:0] pend_instr;
  logic [ADDR_W-1:0]  pend_pc;

  // A bubble never blocks fetch: stall only matters while an output is valid.
  assign hold        = bus.id_valid & bus.id_stall;
  assign bus.if_ready = ~hold & ~bus.flush;
  assign accept      = bus.if_valid & bus.if_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_OP;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (bus.flush) begin
      state_nx = S_OP;
    end else if (accept) begin
      if (state == S_IMM)                  state_nx = S_OP;
      else if (bus.if_instr[IMM_BIT])      state_nx = S_IMM;
    end
  end

  always_comb begin
    complete  = 1'b0;
    pend_load = 1'b0;
    if (accept) begin
      if (state == S_IMM)             complete  = 1'b1;
      else if (bus.if_instr[IMM_BIT]) pend_load = 1'b1;
      else                            complete  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_instr     <= '0;
      pend_pc        <= '0;
      bus.id_valid   <= 1'b0;
      bus.id_instr   <= '0;
      bus.id_imm     <= '0;
      bus.id_pc      <= '0;
      bus.id_has_imm <= 1'b0;
    end else begin
      if (pend_load) begin
        pend_instr <= bus.if_instr;
        pend_pc    <= bus.if_pc;
      end
      if (bus.flush) begin
        bus.id_valid   <= 1'b0;
        bus.id_has_imm <= 1'b0;
      end else if (!hold) begin
        bus.id_valid <= complete;
        // Data regs only move on a completing load; bubbles leave stale values.
        if (complete) begin
          bus.id_instr   <= (state == S_IMM) ? pend_instr : bus.if_instr;
          bus.id_imm     <= (state == S_IMM) ? bus.if_instr : '0;
          bus.id_pc      <= (state == S_IMM) ? pend_pc : bus.if_pc;
          bus.id_has_imm <= (state == S_IMM);
        end
      end
    end
  end
endmodule

// File: tb/tb_fetch_decode_buffer.sv
// tb/tb_fetch_decode_buffer.sv - scoreboard bench for fetch_decode_buffer
// Driver predicts instructions into a queue; a negedge monitor pops and compares.
module tb_fetch_decode_buffer;
  localparam int IMM = 15;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] imm;
    logic [31:0] pc;
    logic        has;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   errors  = 0;

  exp_t        sb[$];
  exp_t        last_exp;
  logic        hold_q = 1'b0;
  logic        m_pend = 1'b0;
  logic        m_out  = 1'b0;
  logic [15:0] m_pinstr;
  logic [31:0] m_ppc;

  fetch_decode_buffer_if #(.ADDR_W(32), .INSTR_W(16)) bus ();

  fetch_decode_buffer #(.ADDR_W(32), .INSTR_W(16), .IMM_BIT(IMM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t cur_out();
    return {bus.id_instr, bus.id_imm, bus.id_pc, bus.id_has_imm};
  endfunction

  always @(posedge clk) begin
    if (!rst) hold_q <= 1'b0;
    else      hold_q <= bus.id_valid & bus.id_stall & ~bus.flush;
  end

  always @(negedge clk) begin
    if (rst && bus.id_valid) begin
      if (hold_q) begin
        chk("hold_frozen", cur_out(), last_exp);
      end else if (sb.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_valid: got %h expected no instruction at %0t", cur_out(), $time);
      end else begin
        last_exp = sb.pop_front();
        chk("sb_out", cur_out(), last_exp);
      end
    end
  end

  // One clock of stimulus; the model works at the instruction level.
  task automatic cycle(input logic v, input logic [15:0] ins, input logic [31:0] pc,
                       input logic st, input logic fl);
    logic exp_ready, acc, completed;
    @(negedge clk);
    bus.if_valid = v;
    bus.if_instr = ins;
    bus.if_pc    = pc;
    bus.id_stall = st;
    bus.flush    = fl;
    #1;
    chk("id_valid", bus.id_valid, m_out);
    exp_ready = !(m_out && st) && !fl;
    chk("if_ready", bus.if_ready, exp_ready);
    acc = v && exp_ready;
    completed = 1'b0;
    if (fl) begin
      m_pend = 1'b0;
    end else if (acc) begin
      if (!m_pend && ins[IMM]) begin
        m_pend   = 1'b1;
        m_pinstr = ins;
        m_ppc    = pc;
      end else begin
        if (m_pend) sb.push_back({m_pinstr, ins, m_ppc, 1'b1});
        else        sb.push_back({ins, 16'h0000, pc, 1'b0});
        m_pend    = 1'b0;
        completed = 1'b1;
      end
    end
    m_out = fl ? 1'b0 : ((m_out && st) ? 1'b1 : completed);
  endtask

  task automatic reset_now();
    #3 rst = 1'b0;
    #1;
    chk("reset_out", {bus.id_valid, bus.id_instr, bus.id_imm, bus.id_pc, bus.id_has_imm}, '0);
    sb.delete();
    m_pend = 1'b0;
    m_out  = 1'b0;
    bus.if_valid = 1'b0;
    bus.id_stall = 1'b0;
    bus.flush    = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("ready_after_reset", bus.if_ready, 1'b1);
  endtask

  initial begin
    bus.if_valid = 1'b0;
    bus.if_instr = '0;
    bus.if_pc    = '0;
    bus.id_stall = 1'b0;
    bus.flush    = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", {bus.id_valid, bus.id_instr, bus.id_imm, bus.id_pc, bus.id_has_imm}, '0);
    rst = 1'b1;
    #1;
    chk("ready_after_reset", bus.if_ready, 1'b1);

    cycle(1, 16'h1234, 32'h20, 0, 0);
    cycle(1, 16'h8005, 32'h21, 0, 0);
    cycle(1, 16'hBEEF, 32'h22, 0, 0);
    cycle(1, 16'h0101, 32'h30, 0, 0);
    repeat (3) cycle(1, 16'h0202, 32'h31, 1, 0);
    cycle(1, 16'h0202, 32'h31, 0, 0);
    cycle(0, 16'h0000, 32'h0, 0, 0);
    cycle(1, 16'h8005, 32'h40, 0, 0);
    cycle(1, 16'h1111, 32'h41, 0, 1);
    cycle(1, 16'h0042, 32'h42, 0, 0);
    cycle(0, 16'h0000, 32'h0, 0, 0);
    cycle(1, 16'h0077, 32'h50, 0, 0);
    cycle(1, 16'h0078, 32'h51, 1, 1);
    cycle(0, 16'h0000, 32'h0, 0, 0);

    cycle(1, 16'h8005, 32'h60, 0, 0);
    cycle(1, 16'hBEEF, 32'h61, 0, 0);
    cycle(1, 16'h8077, 32'h62, 0, 0);
    reset_now();
    cycle(1, 16'h8099, 32'h70, 0, 0);
    cycle(0, 16'h0000, 32'h0, 0, 0);
    reset_now();
    cycle(1, 16'h0042, 32'h71, 0, 0);
    cycle(0, 16'h0000, 32'h0, 0, 0);

    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 3) != 0, 16'($urandom), $urandom,
            $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
    end

    repeat (3) cycle(0, 16'h0000, 32'h0, 0, 0);
    chk("sb_drain", 96'(sb.size()), 96'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
